// File: rtl/display_scheduler.sv
`default_nettype none
//==============================================================================
//  Module      : display_scheduler
//  Description : Owns the 20-bit symbol word (big_bin) that feeds the 4-digit
//                seven-segment multiplexer of the digital lock. The keypad
//                entry view is shown by default. A lock FSM message takes
//                priority and is held for HOLD_CYCLES, optionally blinking.
//                The block also keeps the 4-digit entry buffer and reports it
//                for code comparison.
//  Ports       : clk, rst            - clock, asynchronous active-high reset
//                key_valid/key_digit - keypad digit strobe and BCD value
//                key_clear           - empties the entry buffer
//                msg_req/msg_word/   - message strobe, four 5-bit symbols
//                msg_blink             ([4:0] rightmost) and blink request
//                msg_busy            - a message currently owns the display
//                entry_count/code    - buffered digit count and BCD digits
//                big_bin             - registered symbol word to the mux
//  Revision    : 1.0 - initial release
//==============================================================================
module display_scheduler #(
   parameter int         HOLD_CYCLES  = 8,
   parameter int         BLINK_CYCLES = 4,
   parameter logic [4:0] CODE_DASH    = 5'd16,
   parameter logic [4:0] CODE_BLANK   = 5'd31
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        key_valid,
   input  logic [3:0]  key_digit,
   input  logic        key_clear,
   input  logic        msg_req,
   input  logic [19:0] msg_word,
   input  logic        msg_blink,
   output logic        msg_busy,
   output logic [2:0]  entry_count,
   output logic [15:0] entry_code,
   output logic [19:0] big_bin
);

   localparam int TIMER_W = (HOLD_CYCLES  > 1) ? $clog2(HOLD_CYCLES)  : 1;
   localparam int BCNT_W  = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
   localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(HOLD_CYCLES - 1);
   localparam logic [BCNT_W-1:0]  BCNT_LAST  = BCNT_W'(BLINK_CYCLES - 1);

   typedef enum logic [0:0] {
      ST_ENTRY = 1'b0,
      ST_MSG   = 1'b1
   } state_t;

   state_t               state_q,       state_d;
   logic [19:0]          word_q,        word_d;
   logic                 blink_q,       blink_d;
   logic [TIMER_W-1:0]   timer_q,       timer_d;
   logic [BCNT_W-1:0]    bcnt_q,        bcnt_d;
   logic                 phase_q,       phase_d;
   logic [2:0]           entry_count_q, entry_count_d;
   logic [15:0]          entry_code_q,  entry_code_d;
   logic [19:0]          big_bin_q,     big_bin_d;
   logic [19:0]          entry_view;

   //---------------------------------------------------------------------------
   // State registers
   //---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= ST_ENTRY;
         word_q        <= '0;
         blink_q       <= 1'b0;
         timer_q       <= '0;
         bcnt_q        <= '0;
         phase_q       <= 1'b0;
         entry_count_q <= '0;
         entry_code_q  <= '0;
         big_bin_q     <= {4{CODE_DASH}};
      end else begin
         state_q       <= state_d;
         word_q        <= word_d;
         blink_q       <= blink_d;
         timer_q       <= timer_d;
         bcnt_q        <= bcnt_d;
         phase_q       <= phase_d;
         entry_count_q <= entry_count_d;
         entry_code_q  <= entry_code_d;
         big_bin_q     <= big_bin_d;
      end
   end

   //---------------------------------------------------------------------------
   // Entry buffer: keeps updating while a message is shown. Clear beats a
   // simultaneous key; a full buffer or a non-BCD digit drops the key.
   //---------------------------------------------------------------------------
   always_comb begin
      entry_count_d = entry_count_q;
      entry_code_d  = entry_code_q;
      if (key_clear) begin
         entry_count_d = '0;
         entry_code_d  = '0;
      end else if (key_valid && (key_digit <= 4'd9) && (entry_count_q < 3'd4)) begin
         entry_code_d  = {entry_code_q[11:0], key_digit};
         entry_count_d = entry_count_q + 3'd1;
      end
   end

   //---------------------------------------------------------------------------
   // Entry view: filled positions show their digit, the rest show a dash.
   //---------------------------------------------------------------------------
   for (genvar i = 0; i < 4; i++) begin : g_view
      assign entry_view[5*i +: 5] = (3'(i) < entry_count_q) ?
                                    {1'b0, entry_code_q[4*i +: 4]} : CODE_DASH;
   end

   //---------------------------------------------------------------------------
   // Display ownership FSM
   //---------------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      word_d    = word_q;
      blink_d   = blink_q;
      timer_d   = timer_q;
      bcnt_d    = bcnt_q;
      phase_d   = phase_q;
      big_bin_d = big_bin_q;

      case (state_q)
         ST_ENTRY: begin
            big_bin_d = entry_view;
            if (msg_req) begin
               word_d  = msg_word;
               blink_d = msg_blink;
               timer_d = TIMER_LOAD;
               bcnt_d  = '0;
               phase_d = 1'b0;
               state_d = ST_MSG;
            end
         end
         ST_MSG: begin
            big_bin_d = (blink_q && phase_q) ? {4{CODE_BLANK}} : word_q;
            if (bcnt_q == BCNT_LAST) begin
               bcnt_d  = '0;
               phase_d = ~phase_q;
            end else begin
               bcnt_d  = bcnt_q + BCNT_W'(1);
            end
            // A new request pre-empts the running message, even on its last
            // cycle, and restarts the hold and blink sequence.
            if (msg_req) begin
               word_d  = msg_word;
               blink_d = msg_blink;
               timer_d = TIMER_LOAD;
               bcnt_d  = '0;
               phase_d = 1'b0;
            end else if (timer_q == '0) begin
               state_d = ST_ENTRY;
            end else begin
               timer_d = timer_q - TIMER_W'(1);
            end
         end
         default: state_d = ST_ENTRY;
      endcase
   end

   assign msg_busy    = (state_q == ST_MSG);
   assign entry_count = entry_count_q;
   assign entry_code  = entry_code_q;
   assign big_bin     = big_bin_q;

endmodule
`default_nettype wire

// File: doc/display_scheduler.md
Name: display_scheduler

Overview:
- Owns the 20-bit symbol word (big_bin) that drives the 4-digit seven-segment multiplexer of the digital lock.
- Shares that display between two requesters: the keypad entry path, which is the default owner, and the lock FSM message path, which has priority and is shown for a timed hold with optional blink.
- Keeps the 4-digit entry buffer and reports it to the lock FSM for code comparison.

Parameters:
- HOLD_CYCLES, 8, clock cycles a message stays on the display; must be >=1.
- BLINK_CYCLES, 4, cycles per blink phase while a blinking message is shown; must be >=1.
- CODE_DASH, 5'd16, symbol code for an unfilled entry position.
- CODE_BLANK, 5'd31, symbol code for a dark digit.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- key_valid  in  1  one-cycle strobe: key_digit is valid.
- key_digit  in  4  BCD digit; values >9 are ignored.
- key_clear  in  1  one-cycle strobe: empties the entry buffer.
- msg_req  in  1  one-cycle strobe: show msg_word.
- msg_word  in  20  four 5-bit symbol codes; [4:0] is the rightmost digit.
- msg_blink  in  1  sampled with msg_req; 1 = blink the message.
- msg_busy  out  1  high while a message owns the display.
- entry_count  out  3  digits held in the buffer, 0..4.
- entry_code  out  16  buffered BCD digits; [3:0] is the newest.
- big_bin  out  20  registered symbol word to the seven-segment mux.

Behaviour:
- Reset values (rst asserted; applies immediately, asynchronously):
  - state ENTRY, entry_count 0, entry_code 0, msg_busy 0.
  - Latched word, latched blink flag, hold timer, blink counter and blink phase all 0.
  - big_bin = {4{CODE_DASH}}.
- Entry buffer, updated in every state:
  - key_clear: entry_count<=0, entry_code<=0.
  - key_valid with key_digit<=9 and entry_count<4: entry_code <= {entry_code[11:0], key_digit}; entry_count++.
  - key_valid with entry_count==4 or key_digit>9: ignored.
  - key_clear and key_valid in the same cycle: clear wins and the key is dropped.
- Entry view: display position i (0 = rightmost) shows {1'b0, digit i} if i < entry_count, otherwise CODE_DASH.
- FSM state ENTRY:
  - big_bin <= entry view each cycle.
  - msg_req: latch msg_word and msg_blink; timer <= HOLD_CYCLES-1; blink counter <= 0; phase <= 0 (visible); go to MSG.
- FSM state MSG:
  - msg_busy=1.
  - big_bin <= (latched blink && phase) ? {4{CODE_BLANK}} : latched word.
  - Timer decrements each cycle; at timer==0 with no msg_req, go to ENTRY.
  - msg_req in MSG, including the cycle where timer==0: re-latch word and blink, reload timer, restart blink; stay in MSG (pre-emption).
  - Blink counter counts 0..BLINK_CYCLES-1 and wraps; on wrap, phase toggles.
  - key_clear and key_valid still update the buffer during MSG; they are not shown until return to ENTRY.
- Timing, for msg_req sampled at edge k:
  - msg_busy is high from edge k through edge k+HOLD_CYCLES (exclusive).
  - big_bin carries the message from edge k+1 to edge k+HOLD_CYCLES inclusive.
  - The entry view returns at edge k+HOLD_CYCLES+1.
- Key latency: a key sampled at edge k updates entry_count and entry_code at k; big_bin (in ENTRY) updates at k+1.
- Outputs are registered; there are no combinational input-to-output paths.

Test Plan:
- Reset (HOLD=8, BLINK=2, DASH=16, BLANK=31) -> big_bin=20'h84210, entry_count=0, msg_busy=0.
- Keys 1,2,3 -> entry_count=3, entry_code=16'h0123, big_bin fields [19:15..4:0] = 16,1,2,3. Then keys 4,5 -> entry_code=16'h1234, entry_count=4 (5 is dropped).
- key_digit=4'hA -> no change. key_clear together with key_valid(7) -> entry_count=0 and big_bin=20'h84210 one cycle later.
- msg_req, msg_word=20'h12345, blink=0, at edge k -> msg_busy=1 for exactly 8 cycles; big_bin=20'h12345 on edges k+1..k+8; entry view on edge k+9.
- msg_req with blink=1 -> big_bin sequence W,W,BLANK,BLANK,W,W,BLANK,BLANK over the 8 hold cycles, where BLANK=20'hFFFFF.
- Second msg_req at hold cycle 5 -> new word shown and a full 8-cycle hold restarts. rst asserted mid-message -> msg_busy=0 and big_bin=20'h84210 immediately, with no clock edge needed.
